// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - register map, status/irq bit indices and FSM encodings for the UART APB front-end
package uart_apb_pkg;

    localparam logic [2:0] REG_TXDATA     = 3'd0;
    localparam logic [2:0] REG_RXDATA     = 3'd1;
    localparam logic [2:0] REG_STATUS     = 3'd2;
    localparam logic [2:0] REG_STATUS_CLR = 3'd3;
    localparam logic [2:0] REG_IRQ_EN     = 3'd4;
    localparam logic [2:0] REG_THRESH     = 3'd5;
    localparam logic [2:0] REG_LEVELS     = 3'd6;
    localparam logic [2:0] REG_RSVD       = 3'd7;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_EMPTY    = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_RX_OVF      = 4;
    localparam int ST_PARITY_ERR  = 5;
    localparam int ST_FRAMING_ERR = 6;
    localparam int ST_TX_OVF      = 7;

    localparam int IE_RX_HI = 0;
    localparam int IE_TX_LO = 1;
    localparam int IE_ERR   = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_WRITE, TX_HOLD, TX_WAIT} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_READ, RX_CAPT, RX_WAIT} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and first-word-fall-through head
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_apb_fifo_regif.sv
// rtl/uart_apb_fifo_regif.sv - APB register front-end with TX/RX FIFOs for a FIFO-less UART core
module uart_apb_fifo_regif #(
    parameter int APB_DWIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic [4:0]            PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_DWIDTH-1:0] PWDATA,
    output logic [APB_DWIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  IRQ,
    input  logic                  core_txrdy,
    output logic                  core_wen_n,
    output logic [DATA_WIDTH-1:0] core_tx_data,
    input  logic                  core_rxrdy,
    output logic                  core_oen_n,
    input  logic [DATA_WIDTH-1:0] core_rx_data,
    input  logic                  core_parity_err,
    input  logic                  core_framing_err
);
    import uart_apb_pkg::*;

    localparam int TXLW = $clog2(TX_DEPTH) + 1;
    localparam int RXLW = $clog2(RX_DEPTH) + 1;

    logic                  access, bad_wr, bad_rd, wr_ok, rd_ok;
    logic [2:0]            sel;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_WIDTH-1:0] tx_head, rx_head;
    logic [TXLW-1:0]       tx_level;
    logic [RXLW-1:0]       rx_level;
    logic [7:4]            sticky_q, sticky_d, sticky_set, sticky_clr;
    logic [2:0]            irq_en_q;
    logic [7:0]            rx_thr_q, tx_thr_q, rx_thr_eff;
    logic [7:0]            status;
    logic [15:0]           rdata;
    logic                  rx_hi, tx_lo, unused_ok;
    tx_state_e             tx_state_q;
    rx_state_e             rx_state_q;
    logic                  hold_cnt_q, wen_n_q, oen_n_q;
    logic [DATA_WIDTH-1:0] tx_data_q;

    assign access    = PSEL & PENABLE;
    assign sel       = PADDR[4:2];
    assign PREADY    = 1'b1;
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    always_comb begin
        bad_wr = PWRITE  & ((sel == REG_RXDATA) | (sel == REG_STATUS) | (sel == REG_LEVELS) | (sel == REG_RSVD));
        bad_rd = ~PWRITE & ((sel == REG_TXDATA) | (sel == REG_STATUS_CLR) | (sel == REG_RSVD));
    end

    assign PSLVERR = access & (bad_wr | bad_rd);
    assign wr_ok   = access & PWRITE & ~bad_wr;
    assign rd_ok   = access & ~PWRITE & ~bad_rd;

    assign tx_push = wr_ok & (sel == REG_TXDATA);
    assign tx_pop  = (tx_state_q == TX_IDLE) & ~tx_empty & core_txrdy;
    assign rx_push = (rx_state_q == RX_CAPT);
    assign rx_pop  = rd_ok & (sel == REG_RXDATA) & ~rx_empty;

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(PCLK), .rst_n_i(PRESETN), .push_i(tx_push), .wdata_i(PWDATA[DATA_WIDTH-1:0]),
        .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
    );

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(PCLK), .rst_n_i(PRESETN), .push_i(rx_push), .wdata_i(core_rx_data),
        .pop_i(rx_pop), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
    );

    // Hardware sets are ORed in after the W1C mask so a coincident set survives the clear.
    always_comb begin
        sticky_set                 = '0;
        sticky_set[ST_TX_OVF]      = tx_push & tx_full & ~tx_pop;
        sticky_set[ST_RX_OVF]      = rx_push & rx_full & ~rx_pop;
        sticky_set[ST_PARITY_ERR]  = rx_push & core_parity_err;
        sticky_set[ST_FRAMING_ERR] = rx_push & core_framing_err;
        sticky_clr = (wr_ok && sel == REG_STATUS_CLR) ? PWDATA[7:4] : '0;
        sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
    end

    assign status = {sticky_q, rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        rdata = '0;
        if (rd_ok) begin
            case (sel)
                REG_RXDATA: rdata = rx_empty ? 16'h0 : 16'(rx_head);
                REG_STATUS: rdata = {8'h00, status};
                REG_IRQ_EN: rdata = {13'h0, irq_en_q};
                REG_THRESH: rdata = {tx_thr_q, rx_thr_q};
                REG_LEVELS: rdata = {8'(tx_level), 8'(rx_level)};
                default:    rdata = '0;
            endcase
        end
    end

    assign PRDATA = APB_DWIDTH'(rdata);

    assign rx_thr_eff = (rx_thr_q == 8'd0) ? 8'd1 : rx_thr_q;
    assign rx_hi      = 8'(rx_level) >= rx_thr_eff;
    assign tx_lo      = 8'(tx_level) <= tx_thr_q;
    assign IRQ        = |(irq_en_q & {|sticky_q, tx_lo, rx_hi});

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sticky_q <= '0;
            irq_en_q <= '0;
            rx_thr_q <= '0;
            tx_thr_q <= '0;
        end else begin
            sticky_q <= sticky_d;
            if (wr_ok && sel == REG_IRQ_EN) irq_en_q <= PWDATA[2:0];
            if (wr_ok && sel == REG_THRESH) begin
                rx_thr_q <= PWDATA[7:0];
                tx_thr_q <= PWDATA[15:8];
            end
        end
    end

    // The FIFO pop happens on the IDLE->WRITE edge so the strobe cycle already shows the popped head.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            tx_state_q <= TX_IDLE;
            hold_cnt_q <= 1'b0;
            wen_n_q    <= 1'b1;
            tx_data_q  <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: if (tx_pop) begin
                    tx_state_q <= TX_WRITE;
                    wen_n_q    <= 1'b0;
                    tx_data_q  <= tx_head;
                end
                TX_WRITE: begin
                    tx_state_q <= TX_HOLD;
                    wen_n_q    <= 1'b1;
                    hold_cnt_q <= 1'b0;
                end
                TX_HOLD: begin
                    hold_cnt_q <= 1'b1;
                    if (hold_cnt_q) tx_state_q <= TX_WAIT;
                end
                TX_WAIT: if (core_txrdy) tx_state_q <= TX_IDLE;
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rx_state_q <= RX_IDLE;
            oen_n_q    <= 1'b1;
        end else begin
            case (rx_state_q)
                RX_IDLE: if (core_rxrdy) begin
                    rx_state_q <= RX_READ;
                    oen_n_q    <= 1'b0;
                end
                RX_READ: begin
                    rx_state_q <= RX_CAPT;
                    oen_n_q    <= 1'b1;
                end
                RX_CAPT: rx_state_q <= RX_WAIT;
                RX_WAIT: if (!core_rxrdy) rx_state_q <= RX_IDLE;
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign core_wen_n   = wen_n_q;
    assign core_tx_data = tx_data_q;
    assign core_oen_n   = oen_n_q;

endmodule

// File: tb/tb_uart_apb_fifo_regif.sv
// tb/tb_uart_apb_fifo_regif.sv - directed scoreboard bench for uart_apb_fifo_regif
module tb_uart_apb_fifo_regif;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic [4:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic        PREADY, PSLVERR, IRQ;
    logic        core_txrdy, core_wen_n, core_rxrdy, core_oen_n;
    logic [7:0]  core_tx_data, core_rx_data;
    logic        core_parity_err, core_framing_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_exp [$];
    logic [7:0] rx_exp [$];

    always #5 PCLK = ~PCLK;

    uart_apb_fifo_regif #(.APB_DWIDTH(16), .DATA_WIDTH(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .IRQ(IRQ), .core_txrdy(core_txrdy), .core_wen_n(core_wen_n), .core_tx_data(core_tx_data),
        .core_rxrdy(core_rxrdy), .core_oen_n(core_oen_n), .core_rx_data(core_rx_data),
        .core_parity_err(core_parity_err), .core_framing_err(core_framing_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_tx();
        if (tx_exp.size() == 0) return 32'hDEAD;
        return 32'(tx_exp.pop_front());
    endfunction

    function automatic logic [31:0] pop_rx();
        if (rx_exp.size() == 0) return 32'hDEAD;
        return 32'(rx_exp.pop_front());
    endfunction

    task automatic apb_write(input logic [2:0] r, input logic [15:0] d, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {r, 2'b00}; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] r, output logic [15:0] d, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {r, 2'b00};
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 begin d = PRDATA; err = PSLVERR; end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] r, input logic [15:0] exp);
        logic [15:0] d;
        logic e;
        apb_read(r, d, e);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [2:0] r, input logic [15:0] d);
        logic e;
        apb_write(r, d, e);
    endtask

    task automatic tx_drain(input int n);
        int cnt = 0;
        core_txrdy = 1'b1;
        repeat (n * 6 + 10) begin
            @(negedge PCLK);
            if (!core_wen_n) begin
                chk("tx_char", core_tx_data, pop_tx());
                cnt++;
            end
        end
        chk("tx_pulse_count", cnt, n);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic perr, input logic ferr);
        logic seen = 1'b0;
        @(negedge PCLK);
        core_rx_data = d; core_parity_err = perr; core_framing_err = ferr; core_rxrdy = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge PCLK);
            if (!core_oen_n) seen = 1'b1;
        end
        if (!seen) chk("rx_oen_timeout", 32'(seen), 32'd1);
        @(negedge PCLK);
        @(negedge PCLK);
        core_rxrdy = 1'b0; core_parity_err = 1'b0; core_framing_err = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic rx_drain(input int n);
        logic [15:0] d;
        logic e;
        for (int i = 0; i < n; i++) begin
            apb_read(3'd1, d, e);
            chk("rx_char", d, pop_rx());
        end
    endtask

    initial begin
        logic [15:0] d;
        logic e;

        PRESETN = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
        core_txrdy = 1'b0; core_rxrdy = 1'b0; core_rx_data = '0;
        core_parity_err = 1'b0; core_framing_err = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_irq", IRQ, 1'b0);
        chk("rst_wen_n", core_wen_n, 1'b1);
        chk("rst_oen_n", core_oen_n, 1'b1);
        chk("rst_tx_data", core_tx_data, 8'h00);
        chk("rst_prdata", PRDATA, 16'h0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        PRESETN = 1'b1;
        rd_chk("rst_status", 3'd2, 16'h0006);
        rd_chk("rst_levels", 3'd6, 16'h0000);
        chk("pready", PREADY, 1'b1);

        apb_write(3'd1, 16'h00FF, e);
        chk("wr_rxdata_slverr", e, 1'b1);
        apb_read(3'd0, d, e);
        chk("rd_txdata_slverr", e, 1'b1);
        chk("rd_txdata_zero", d, 16'h0);
        apb_read(3'd7, d, e);
        chk("rd_rsvd_slverr", e, 1'b1);
        rd_chk("status_after_err", 3'd2, 16'h0006);
        rd_chk("levels_after_err", 3'd6, 16'h0000);

        for (int i = 0; i < 3; i++) begin
            wr(3'd0, 16'(8'h41 + i));
            tx_exp.push_back(8'(8'h41 + i));
        end
        rd_chk("tx_level3", 3'd6, 16'h0300);
        tx_drain(3);
        rd_chk("tx_empty_again", 3'd2, 16'h0006);

        core_txrdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr(3'd0, 16'(8'h50 + i));
            if (i < 16) tx_exp.push_back(8'(8'h50 + i));
        end
        rd_chk("tx_full_ovf", 3'd2, 16'h0085);
        rd_chk("tx_level16", 3'd6, 16'h1000);
        wr(3'd3, 16'h0080);
        rd_chk("tx_ovf_cleared", 3'd2, 16'h0005);
        tx_drain(16);
        core_txrdy = 1'b0;
        rd_chk("tx_drained", 3'd2, 16'h0006);

        for (int i = 0; i < 17; i++) begin
            send_rx(8'(8'h60 + i), 1'b0, 1'b0);
            if (i < 16) rx_exp.push_back(8'(8'h60 + i));
        end
        rd_chk("rx_full_ovf", 3'd2, 16'h001A);
        rd_chk("rx_level16", 3'd6, 16'h0010);
        rx_drain(16);
        apb_read(3'd1, d, e);
        chk("rx_empty_read", d, 16'h0);
        chk("rx_empty_noerr", e, 1'b0);
        wr(3'd3, 16'h0010);
        rd_chk("rx_ovf_cleared", 3'd2, 16'h0006);

        wr(3'd5, 16'h0004);
        wr(3'd4, 16'h0001);
        rd_chk("thresh_rb", 3'd5, 16'h0004);
        rd_chk("irq_en_rb", 3'd4, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            send_rx(8'(8'h70 + i), 1'b0, 1'b0);
            rx_exp.push_back(8'(8'h70 + i));
        end
        chk("irq_below_thr", IRQ, 1'b0);
        send_rx(8'h73, 1'b0, 1'b0);
        rx_exp.push_back(8'h73);
        chk("irq_at_thr", IRQ, 1'b1);
        rx_drain(1);
        chk("irq_after_pop", IRQ, 1'b0);
        rx_drain(3);

        @(negedge PCLK);
        core_rx_data = 8'h77; core_parity_err = 1'b1; core_rxrdy = 1'b1;
        rx_exp.push_back(8'h77);
        @(negedge PCLK);
        chk("oen_strobe", core_oen_n, 1'b0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {3'd3, 2'b00}; PWDATA = 16'h0020;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        core_rxrdy = 1'b0; core_parity_err = 1'b0;
        repeat (2) @(negedge PCLK);
        rd_chk("parity_set_wins", 3'd2, 16'h0022);
        chk("irq_err_masked", IRQ, 1'b0);
        wr(3'd4, 16'h0004);
        chk("irq_err", IRQ, 1'b1);
        wr(3'd3, 16'h0020);
        chk("irq_err_cleared", IRQ, 1'b0);
        rd_chk("parity_cleared", 3'd2, 16'h0002);
        rx_drain(1);

        send_rx(8'h15, 1'b0, 1'b1);
        rx_exp.push_back(8'h15);
        rd_chk("framing_set", 3'd2, 16'h0042);
        rx_drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
